char_prefetch_reader: RTL and testbench

CHAR_PREFETCH_READER -- requirements
Module: char_prefetch_reader

---
 rtl/char_prefetch_reader_pkg.sv | 14 +
 rtl/char_prefetch_reader_fifo.sv | 60 ++++++
 rtl/char_prefetch_reader.sv | 119 +++++++++++
 tb/tb_char_prefetch_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/char_prefetch_reader_pkg.sv
// Shared character constants and fetch FSM state encodings for the document
// reader and the parser that consumes it.
package char_prefetch_reader_pkg;

    localparam int CHAR_BITES = 8;
    localparam logic [CHAR_BITES-1:0] CHAR_EOF = 8'h00;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_END   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/char_prefetch_reader_fifo.sv
// Small circular FIFO of characters.
// Latency: a push is visible at dout on the cycle after it is written.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLOCK_50) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/char_prefetch_reader.sv
// Prefetches a zero-terminated document from an external ROM into a FIFO and presents it one char at a time.
// Latency: next char 1 cycle after next_char; first char appears 4 cycles after reset release.
// Backpressure: reads stop while the char register, FIFO and in-flight byte already hold DEPTH bytes.
module char_prefetch_reader
    import char_prefetch_reader_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 4,
    parameter int MAX_LEN = 4096
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  next_char,
    input  logic [CHAR_BITES-1:0] rom_data,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic                  rom_rd,
    output logic [CHAR_BITES-1:0] char,
    output logic                  char_valid,
    output logic                  eof
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_TOP  = '1;

    fetch_state_t          state;
    logic                  rd_q;
    logic                  rd_last;
    logic [CHAR_BITES-1:0] fifo_dout;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  ret_term;
    logic                  ret_final;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  can_issue;
    logic [CNT_W:0]        occupancy;

    // rd_q marks the cycle in which rom_data carries the byte of the previous read.
    assign ret_term  = rd_q && (rom_data == CHAR_EOF);
    assign ret_final = rd_q && (ret_term || rd_last);
    assign fifo_push = rd_q && !ret_term;
    assign fifo_pop  = !fifo_empty && (state != ST_END) && (!char_valid || next_char);

    // The presented char counts against capacity so an idle consumer stalls reads after DEPTH bytes.
    assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(char_valid) + (CNT_W+1)'(rd_q);
    assign can_issue = (state == ST_FILL) && !rom_rd && !ret_final && !fifo_full
                       && (occupancy < (CNT_W+1)'(DEPTH));

    char_fifo #(
        .WIDTH (CHAR_BITES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .din      (rom_data),
        .dout     (fifo_dout),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_FILL;
            rom_addr   <= '0;
            rom_rd     <= 1'b0;
            rd_q       <= 1'b0;
            rd_last    <= 1'b0;
            char       <= CHAR_EOF;
            char_valid <= 1'b0;
            eof        <= 1'b0;
        end else begin
            rd_q   <= rom_rd;
            rom_rd <= can_issue;
            if (can_issue) begin
                rd_last <= (rom_addr == LAST_ADDR);
            end
            if (rom_rd && (rom_addr != ADDR_TOP)) begin
                rom_addr <= rom_addr + ADDR_W'(1);
            end

            if (fifo_pop) begin
                char       <= fifo_dout;
                char_valid <= 1'b1;
            end else if (next_char && char_valid) begin
                char_valid <= 1'b0;
            end

            case (state)
                ST_FILL: begin
                    if (ret_final) begin
                        // Nothing buffered and nothing arriving: skip DRAIN entirely.
                        if (fifo_empty && !char_valid && !fifo_push) begin
                            state <= ST_END;
                            eof   <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !char_valid) begin
                        state <= ST_END;
                        eof   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_END;
                    eof   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_prefetch_reader.sv
// Directed bench for char_prefetch_reader with a document-level reference model.
module tb_char_prefetch_reader;

    logic        CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic        resetn, next_char, rom_rd, char_valid, eof;
    logic [7:0]  rom_data, char;
    logic [11:0] rom_addr;

    logic        resetn_b, next_char_b, rom_rd_b, char_valid_b, eof_b;
    logic [7:0]  rom_data_b, char_b;
    logic [11:0] rom_addr_b;

    char_prefetch_reader #(.ADDR_W(12), .DEPTH(4), .MAX_LEN(4096)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .next_char(next_char), .rom_data(rom_data),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .char(char), .char_valid(char_valid), .eof(eof)
    );

    char_prefetch_reader #(.ADDR_W(12), .DEPTH(4), .MAX_LEN(5)) dut_b (
        .CLOCK_50(CLOCK_50), .resetn(resetn_b), .next_char(next_char_b), .rom_data(rom_data_b),
        .rom_addr(rom_addr_b), .rom_rd(rom_rd_b), .char(char_b), .char_valid(char_valid_b), .eof(eof_b)
    );

    // External ROMs: data valid the cycle after a strobed address, garbage otherwise.
    logic [7:0] rom [0:4095];
    always @(posedge CLOCK_50) rom_data   <= rom_rd   ? rom[rom_addr] : 8'hEE;
    always @(posedge CLOCK_50) rom_data_b <= rom_rd_b ? 8'h41 : 8'hEE;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the document is every byte from address 0 up to the
    // terminator or the length limit, delivered in order exactly once.
    logic [7:0] exp_q[$];
    task automatic build_model(input int max_len);
        exp_q.delete();
        for (int a = 0; a < max_len; a++) begin
            if (rom[a] == 8'h00) break;
            exp_q.push_back(rom[a]);
        end
    endtask

    int         idx, nreads, ncons;
    bit         prev_cv, cons_q, eof_seen;
    logic [7:0] got[$];

    always @(negedge CLOCK_50) begin
        if (!resetn) begin
            idx = 0; nreads = 0; ncons = 0;
            prev_cv = 1'b0; cons_q = 1'b0; eof_seen = 1'b0;
            got.delete();
        end else begin
            if (char_valid && (!prev_cv || cons_q)) begin
                got.push_back(char);
                if (idx < exp_q.size()) check("char_order", char, exp_q[idx]);
                else                    check("extra_char", idx, exp_q.size());
                idx++;
            end
            if (rom_rd) begin
                check("rd_addr_seq", rom_addr, nreads);
                nreads++;
                check("prefetch_bound", (nreads - ncons) <= 4, 1);
            end
            if (eof_seen) check("eof_sticky", eof, 1);
            if (eof) begin
                check("end_quiet", {char_valid, rom_rd}, 0);
                if (!eof_seen) check("all_delivered", idx, exp_q.size());
                eof_seen = 1'b1;
            end
            cons_q = next_char && char_valid;
            if (cons_q) ncons++;
            prev_cv = char_valid;
        end
    end

    int nreads_b, ncons_b, bad_b;
    always @(negedge CLOCK_50) begin
        if (!resetn_b) begin
            nreads_b = 0; ncons_b = 0; bad_b = 0;
        end else begin
            if (rom_rd_b) begin
                nreads_b++;
                if (rom_addr_b >= 12'd5) bad_b++;
            end
            if (next_char_b && char_valid_b) begin
                ncons_b++;
                check("b_char", char_b, 8'h41);
            end
        end
    end

    task automatic hold_reset();
        resetn = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic release_reset();
        @(posedge CLOCK_50);
        #1 resetn = 1'b1;
    endtask

    task automatic wait_eof(input int bound, input string name);
        int c = 0;
        while (!eof && c < bound) begin
            @(posedge CLOCK_50); #1;
            c++;
        end
        check(name, eof, 1);
    endtask

    initial begin
        resetn = 1'b0; next_char = 1'b0;
        resetn_b = 1'b0; next_char_b = 1'b0;
        for (int a = 0; a < 4096; a++) rom[a] = 8'h00;

        // Reset values
        hold_reset();
        check("rst_addr", rom_addr, 0);
        check("rst_rd", rom_rd, 0);
        check("rst_char", char, 0);
        check("rst_valid", char_valid, 0);
        check("rst_eof", eof, 0);

        // "ab<00>" with next_char held high
        rom[0] = 8'h61; rom[1] = 8'h62; rom[2] = 8'h00;
        build_model(4096);
        next_char = 1'b1;
        release_reset();
        wait_eof(60, "t1_eof");
        check("t1_count", got.size(), 2);
        if (got.size() == 2) begin
            check("t1_first", got[0], 8'h61);
            check("t1_second", got[1], 8'h62);
        end
        check("t1_valid", char_valid, 0);
        check("t1_addr", rom_addr, 3);
        check("t1_reads", nreads, 3);
        for (int i = 0; i < 6; i++) begin
            @(posedge CLOCK_50); #1 next_char = ~next_char;
        end
        check("t1_end_addr", rom_addr, 3);
        check("t1_end_reads", nreads, 3);

        // Empty document
        hold_reset();
        rom[0] = 8'h00;
        build_model(4096);
        next_char = 1'b0;
        release_reset();
        repeat (3) @(posedge CLOCK_50);
        #1 check("t2_eof_by_3", eof, 1);
        repeat (5) @(posedge CLOCK_50);
        #1;
        check("t2_no_chars", got.size(), 0);
        check("t2_one_read", nreads, 1);

        // Ten bytes, consumer idle
        hold_reset();
        for (int i = 0; i < 10; i++) rom[i] = 8'h30 + 8'(i);
        rom[10] = 8'h00;
        build_model(4096);
        release_reset();
        repeat (40) @(posedge CLOCK_50);
        #1;
        check("t3_reads", nreads, 4);
        check("t3_char", char, 8'h30);
        check("t3_valid", char_valid, 1);
        repeat (20) @(posedge CLOCK_50);
        #1 check("t3_rd_held", nreads, 4);

        // Reset in the middle after three consumed characters
        begin
            int c = 0;
            next_char = 1'b1;
            while (ncons < 3 && c < 100) begin
                @(posedge CLOCK_50); #1;
                c++;
            end
            check("t4_consumed", ncons, 3);
        end
        resetn = 1'b0; next_char = 1'b0;
        #1;
        check("t4_rst_addr", rom_addr, 0);
        check("t4_rst_rd", rom_rd, 0);
        check("t4_rst_char", char, 0);
        check("t4_rst_valid", char_valid, 0);
        check("t4_rst_eof", eof, 0);
        release_reset();
        begin
            int c = 0;
            while (!char_valid && c < 20) begin
                @(posedge CLOCK_50); #1;
                c++;
            end
            check("t4_restart_valid", char_valid, 1);
            check("t4_restart_char", char, 8'h30);
        end

        // Alternating next_char against a filled buffer
        hold_reset();
        for (int i = 0; i < 12; i++) rom[i] = 8'h61 + 8'(i);
        rom[12] = 8'h00;
        build_model(4096);
        next_char = 1'b0;
        release_reset();
        repeat (30) @(posedge CLOCK_50);
        begin
            int c = 0;
            while (!eof && c < 300) begin
                @(posedge CLOCK_50); #1 next_char = ~next_char;
                c++;
            end
        end
        check("t5_eof", eof, 1);
        check("t5_count", got.size(), 12);
        if (got.size() == 12) check("t5_last", got[11], 8'h6C);
        next_char = 1'b0;

        // Length limit of five bytes, ROM full of 'A'
        next_char_b = 1'b1;
        @(posedge CLOCK_50);
        #1 resetn_b = 1'b1;
        begin
            int c = 0;
            while (!eof_b && c < 80) begin
                @(posedge CLOCK_50); #1;
                c++;
            end
        end
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("t6_eof", eof_b, 1);
        check("t6_chars", ncons_b, 5);
        check("t6_reads", nreads_b, 5);
        check("t6_no_read_past_limit", bad_b, 0);
        check("t6_addr", rom_addr_b, 5);
        check("t6_valid", char_valid_b, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
